// File: rtl/demux_pkg.sv
// Shared types for the packet-aware 1:2 stream demux.
//   route_state_e : routing FSM state (IDLE, or locked onto output A or B)
//   SEL_A / SEL_B : values of sel_i, and lane indices of the A and B outputs
package demux_pkg;

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} route_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready register stage.
//   clk_i, rst_ni : clock, async active-low reset
//   load          : write in_data this cycle (caller only loads when free=1)
//   in_data       : payload to capture
//   free          : stage can take a beat this cycle (empty or draining)
//   out_valid     : stage holds a beat
//   out_ready     : downstream takes the beat
//   out_data      : held payload, stable while out_valid && !out_ready
module stream_reg #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         free,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign free = !out_valid || out_ready;

  // A load in the same cycle as a drain is a back-to-back transfer:
  // the new beat replaces the one leaving, and valid stays high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Packet-aware 1:2 stream demux. Routing is chosen by sel_i on the first
// beat of a packet and held until its last beat; each output has a
// one-entry register stage and a wrapping count of packets routed to it.
//   clk_i, rst_ni                       : clock, async active-low reset
//   in_data_i/in_last_i/in_valid_i/in_ready_o : input stream
//   sel_i                               : 0 = A, 1 = B (first beat only)
//   a_* / b_*                           : output streams A and B
//   a_pkt_cnt_o / b_pkt_cnt_o           : last beats accepted toward A / B
//   busy_o                              : a packet is mid-route
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [BIT_WIDTH-1:0] in_data_i,
  input  logic                 in_last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 sel_i,
  output logic [BIT_WIDTH-1:0] a_data_o,
  output logic                 a_last_o,
  output logic                 a_valid_o,
  input  logic                 a_ready_i,
  output logic [BIT_WIDTH-1:0] b_data_o,
  output logic                 b_last_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [CNT_WIDTH-1:0] a_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] b_pkt_cnt_o,
  output logic                 busy_o
);

  localparam int NUM_LANES = 2;

  route_state_e state_q, state_d;
  logic         target;
  logic         accept;

  // Lane 0 is output A, lane 1 is output B; payload is {last, data}.
  logic [NUM_LANES-1:0]                lane_load;
  logic [NUM_LANES-1:0]                lane_free;
  logic [NUM_LANES-1:0]                lane_vld;
  logic [NUM_LANES-1:0]                lane_rdy;
  logic [NUM_LANES-1:0][BIT_WIDTH:0]   lane_q;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0] pkt_cnt;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: lock onto the target after a non-last first beat,
  // release after the last beat.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE:    if (!in_last_i) state_d = (target == SEL_B) ? LOCK_B : LOCK_A;
        LOCK_A,
        LOCK_B:  if (in_last_i)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: sel_i only steers in IDLE, so in_ready_o never depends on
  // in_valid_i.
  always_comb begin
    unique case (state_q)
      LOCK_A:  target = SEL_A;
      LOCK_B:  target = SEL_B;
      default: target = sel_i;
    endcase
    busy_o = (state_q != IDLE);
  end

  assign in_ready_o = lane_free[target];
  assign accept     = in_valid_i && in_ready_o;
  assign lane_rdy   = {b_ready_i, a_ready_i};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_load[i] = accept && (target == 1'(i));

    stream_reg #(.W(BIT_WIDTH + 1)) u_reg (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load      (lane_load[i]),
      .in_data   ({in_last_i, in_data_i}),
      .free      (lane_free[i]),
      .out_valid (lane_vld[i]),
      .out_ready (lane_rdy[i]),
      .out_data  (lane_q[i])
    );

    // Wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                       pkt_cnt[i] <= '0;
      else if (lane_load[i] && in_last_i) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
    end
  end

  assign {a_last_o, a_data_o} = lane_q[SEL_A];
  assign {b_last_o, b_data_o} = lane_q[SEL_B];
  assign a_valid_o   = lane_vld[SEL_A];
  assign b_valid_o   = lane_vld[SEL_B];
  assign a_pkt_cnt_o = pkt_cnt[SEL_A];
  assign b_pkt_cnt_o = pkt_cnt[SEL_B];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: directed packets plus randomized traffic,
// checked every cycle against a queue-based model of the two outputs.
module tb_demux_1to2_stream;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [BW-1:0] in_data_i;
  logic          in_last_i, in_valid_i, in_ready_o, sel_i;
  logic [BW-1:0] a_data_o, b_data_o;
  logic          a_last_o, a_valid_o, a_ready_i;
  logic          b_last_o, b_valid_o, b_ready_i;
  logic [CW-1:0] a_pkt_cnt_o, b_pkt_cnt_o;
  logic          busy_o;

  demux_1to2_stream #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .sel_i(sel_i),
    .a_data_o(a_data_o), .a_last_o(a_last_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
    .b_data_o(b_data_o), .b_last_o(b_last_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .a_pkt_cnt_o(a_pkt_cnt_o), .b_pkt_cnt_o(b_pkt_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what each output is holding, the packet currently being routed,
  // and how many packets finished toward each side.
  logic [BW:0] qa[$];
  logic [BW:0] qb[$];
  bit          locked;
  bit          lock_tgt;
  int          cnt_a, cnt_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cur_tgt();
    return locked ? lock_tgt : sel_i;
  endfunction

  function automatic bit model_ready();
    bit fa, fb;
    fa = (qa.size() == 0) || a_ready_i;
    fb = (qb.size() == 0) || b_ready_i;
    return cur_tgt() ? fb : fa;
  endfunction

  task automatic compare();
    chk("a_valid", a_valid_o, qa.size() != 0);
    if (qa.size() != 0) chk("a_beat", {a_last_o, a_data_o}, qa[0]);
    chk("b_valid", b_valid_o, qb.size() != 0);
    if (qb.size() != 0) chk("b_beat", {b_last_o, b_data_o}, qb[0]);
    chk("in_ready", in_ready_o, model_ready());
    chk("busy", busy_o, locked);
    chk("a_cnt", a_pkt_cnt_o, cnt_a);
    chk("b_cnt", b_pkt_cnt_o, cnt_b);
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the
  // model across the rising edge using the same inputs.
  task automatic step(input bit v, input logic [BW-1:0] d, input bit l,
                      input bit s, input bit ar, input bit br);
    bit acc, t;
    @(negedge clk_i);
    in_valid_i = v; in_data_i = d; in_last_i = l; sel_i = s;
    a_ready_i = ar; b_ready_i = br;
    #1;
    compare();
    @(posedge clk_i);
    acc = in_valid_i && model_ready();
    t   = cur_tgt();
    if (qa.size() != 0 && a_ready_i) void'(qa.pop_front());
    if (qb.size() != 0 && b_ready_i) void'(qb.pop_front());
    if (acc) begin
      if (t) qb.push_back({l, d});
      else   qa.push_back({l, d});
      if (l) begin
        locked = 1'b0;
        if (t) cnt_b = (cnt_b + 1) % (1 << CW);
        else   cnt_a = (cnt_a + 1) % (1 << CW);
      end else begin
        locked   = 1'b1;
        lock_tgt = t;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    chk("rst_a_valid", a_valid_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    qa.delete(); qb.delete();
    locked = 1'b0; lock_tgt = 1'b0; cnt_a = 0; cnt_b = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1;
    in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0; sel_i = 1'b0;
    a_ready_i = 1'b1; b_ready_i = 1'b1;
    do_reset();

    // Reset state, both outputs ready.
    #1;
    chk("t1_a_data", a_data_o, 0);
    chk("t1_b_data", b_data_o, 0);
    chk("t1_a_last", a_last_o, 0);
    chk("t1_cnt", {a_pkt_cnt_o, b_pkt_cnt_o}, 0);
    chk("t1_in_ready", in_ready_o, 1);

    // Single-beat packet to A.
    step(1, 8'h5A, 1, 0, 1, 1);
    #1;
    chk("t2_a_valid", a_valid_o, 1);
    chk("t2_a_data", a_data_o, 8'h5A);
    chk("t2_a_cnt", a_pkt_cnt_o, 1);
    chk("t2_b_valid", b_valid_o, 0);

    // Three-beat packet to B; sel_i changes mid-packet and must be ignored.
    step(1, 8'h11, 0, 1, 1, 1);
    #1 chk("t3_busy1", busy_o, 1);
    step(1, 8'h22, 0, 0, 1, 1);
    #1 chk("t3_b_data2", b_data_o, 8'h22);
    step(1, 8'h33, 1, 0, 1, 1);
    #1;
    chk("t3_busy3", busy_o, 0);
    chk("t3_b_data3", b_data_o, 8'h33);
    chk("t3_b_cnt", b_pkt_cnt_o, 1);
    chk("t3_a_valid", a_valid_o, 0);

    // A holds a beat while B fills and stalls; A then drains regardless.
    step(1, 8'hA1, 1, 0, 0, 1);
    step(1, 8'hB1, 0, 1, 0, 0);
    step(1, 8'hB2, 1, 1, 1, 0);
    #1;
    chk("t4_in_ready", in_ready_o, 0);
    chk("t4_b_data", b_data_o, 8'hB1);
    chk("t4_a_valid", a_valid_o, 0);
    // Stall B a few more cycles, then release: B1 then B2, nothing lost.
    repeat (4) step(1, 8'hB2, 1, 1, 1, 0);
    #1 chk("t5_b_hold", b_data_o, 8'hB1);
    step(1, 8'hB2, 1, 1, 1, 1);
    #1 chk("t5_b_next", b_data_o, 8'hB2);
    step(0, 8'h00, 0, 0, 1, 1);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 2) == 0,
           1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    repeat (3) step(0, 8'h00, 0, 0, 1, 1);

    // Counter wrap: 17 packets to A with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, BW'(i), 1, 0, 1, 1);
    #1 chk("t6_wrap", a_pkt_cnt_o, 1);

    // Reset in the middle of a packet headed to a stalled B.
    step(1, 8'h77, 0, 1, 1, 0);
    #1;
    chk("t6_b_valid_pre", b_valid_o, 1);
    chk("t6_busy_pre", busy_o, 1);
    do_reset();
    step(1, 8'h66, 1, 0, 1, 1);
    step(0, 8'h00, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
